// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder used for each serial step of serial_adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, valid/ready on both sides.
// Defining SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             busy,
  output logic             ovf
`else
  output logic             busy
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             s_bit, c_bit;
  logic             last;

  fa_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (s_bit),
    .carry(c_bit)
  );

  assign last = (state_q == RUN) && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
          carry_q <= c_bit;
          if (!last) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic msb_cin_q;

  // Carry into the MSB is the carry register during the final RUN step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    msb_cin_q <= 1'b0;
    else if (last) msb_cin_q <= carry_q;
  end

  assign ovf = (state_q == DONE) & (msb_cin_q ^ carry_q);
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule
